// File: rtl/multi_mode_shift_engine.sv
// ---------------------------------------------------------------------------
// multi_mode_shift_engine
//
// Parametrised shift/rotate register with a burst engine. It provides eight
// operations: hold, logical shift right/left with serial fill, parallel load,
// rotate right/left, arithmetic shift right and clear. All shifts and rotates
// move the register by a variable amount. The bit that leaves the register is
// kept in a register.
//
// The burst engine latches one operation and repeats it burst_len times. It
// then raises a one-cycle done pulse. busy is high while the burst runs.
//
// Ports
//   clk              rising-edge clock
//   rst              asynchronous active-high reset
//   enable           clock enable; 0 freezes q, shift_out, FSM and counter
//   mode             operation select (HOLD/SRL/SLL/LOAD/ROR/ROL/SRA/CLEAR)
//   amount           shift/rotate distance for each operation
//   serial_in_right  fill bit for SRL (enters at the MSB side)
//   serial_in_left   fill bit for SLL (enters at the LSB side)
//   parallel_in      load value
//   start            launch a burst (sampled in IDLE while enable=1)
//   burst_len        number of operations in a burst
//   q                register contents
//   shift_out        last bit shifted or rotated out
//   busy             high while a burst is running
//   done             one-cycle pulse when a burst completes
// ---------------------------------------------------------------------------
module multi_mode_shift_engine #(
   parameter  int WIDTH = 8,
   parameter  int CNT_W = 8,
   localparam int AMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [2:0]       mode,
   input  logic [AMT_W-1:0] amount,
   input  logic             serial_in_right,
   input  logic             serial_in_left,
   input  logic [WIDTH-1:0] parallel_in,
   input  logic             start,
   input  logic [CNT_W-1:0] burst_len,
   output logic [WIDTH-1:0] q,
   output logic             shift_out,
   output logic             busy,
   output logic             done
);

   // Operation encodings
   localparam logic [2:0] M_HOLD  = 3'b000;
   localparam logic [2:0] M_SRL   = 3'b001;
   localparam logic [2:0] M_SLL   = 3'b010;
   localparam logic [2:0] M_LOAD  = 3'b011;
   localparam logic [2:0] M_ROR   = 3'b100;
   localparam logic [2:0] M_ROL   = 3'b101;
   localparam logic [2:0] M_SRA   = 3'b110;
   localparam logic [2:0] M_CLEAR = 3'b111;

   // The shift amount is widened by one bit. This lets the modulo and
   // index arithmetic hold WIDTH itself and sums up to 2*WIDTH-2.
   localparam int              SH_W  = AMT_W + 1;
   localparam logic [SH_W-1:0] W_X   = SH_W'(WIDTH);
   localparam logic [SH_W-1:0] W_M1  = SH_W'(WIDTH - 1);
   localparam logic [SH_W-1:0] ONE_X = SH_W'(1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t             state_q,    state_d;
   logic [CNT_W-1:0]   cnt_q,      cnt_d;
   logic [2:0]         lat_mode_q, lat_mode_d;
   logic [AMT_W-1:0]   lat_amt_q,  lat_amt_d;
   logic [WIDTH-1:0]   q_q,        q_d;
   logic               so_q,       so_d;
   logic               busy_q,     busy_d;
   logic               done_q,     done_d;

   // Operation currently applied to the datapath
   logic               exec;
   logic [2:0]         op_mode;
   logic [AMT_W-1:0]   op_amt;

   // ------------------------------------------------------------------
   // Shift / rotate datapath
   // ------------------------------------------------------------------
   logic [SH_W-1:0]    amt_x;
   logic [SH_W-1:0]    amt_m1;
   logic [SH_W-1:0]    rot_x;
   logic [SH_W-1:0]    ror_idx;
   logic [SH_W-1:0]    rol_idx;

   logic [2*WIDTH-1:0] srl_cat;
   logic [2*WIDTH-1:0] sra_cat;
   logic [2*WIDTH-1:0] sll_cat;
   logic [2*WIDTH-1:0] rot_cat;

   logic [WIDTH-1:0]   srl_res, sra_res, sll_res, ror_res, rol_res;
   logic               srl_out, sra_out, sll_out, ror_out, rol_out;

   // In a burst the latched operation drives the datapath. parallel_in is
   // always the live input, so a latched LOAD picks up the current value.
   assign op_mode = (state_q == S_RUN) ? lat_mode_q : mode;
   assign op_amt  = (state_q == S_RUN) ? lat_amt_q  : amount;

   assign amt_x  = {1'b0, op_amt};
   // amt_m1 is used only when the amount is non-zero.
   assign amt_m1 = amt_x - ONE_X;
   assign rot_x  = amt_x % W_X;

   // Shifts work on a double-width word. The fill bits sit beside q, so an
   // amount of WIDTH or more fills the whole register. The exiting bit is
   // the bit one position short of the full shift.
   assign srl_cat = {{WIDTH{serial_in_right}}, q_q};
   assign sra_cat = {{WIDTH{q_q[WIDTH-1]}}, q_q};
   assign sll_cat = {q_q, {WIDTH{serial_in_left}}};
   assign rot_cat = {q_q, q_q};

   assign srl_res = WIDTH'(srl_cat >> amt_x);
   assign srl_out = 1'(srl_cat >> amt_m1);

   assign sra_res = WIDTH'(sra_cat >> amt_x);
   assign sra_out = 1'(sra_cat >> amt_m1);

   assign sll_res = WIDTH'((sll_cat << amt_x) >> WIDTH);
   assign sll_out = 1'((sll_cat << amt_m1) >> (2 * WIDTH - 1));

   // Rotates use amount mod WIDTH. The exiting bit is the original bit
   // at index (a-1) mod WIDTH for ROR, and (WIDTH-a) mod WIDTH for ROL.
   assign ror_idx = (rot_x + W_M1) % W_X;
   assign rol_idx = (W_X - rot_x) % W_X;

   assign ror_res = WIDTH'(rot_cat >> rot_x);
   assign ror_out = 1'(rot_cat >> ror_idx);

   assign rol_res = WIDTH'((rot_cat << rot_x) >> WIDTH);
   assign rol_out = 1'(rot_cat >> rol_idx);

   always_comb begin
      q_d  = q_q;
      so_d = so_q;
      if (exec) begin
         case (op_mode)
            M_HOLD: begin
               q_d = q_q;
            end
            M_SRL: begin
               if (op_amt != '0) begin
                  q_d  = srl_res;
                  so_d = srl_out;
               end
            end
            M_SLL: begin
               if (op_amt != '0) begin
                  q_d  = sll_res;
                  so_d = sll_out;
               end
            end
            M_LOAD: begin
               q_d = parallel_in;
            end
            M_ROR: begin
               if (op_amt != '0) begin
                  q_d  = ror_res;
                  so_d = ror_out;
               end
            end
            M_ROL: begin
               if (op_amt != '0) begin
                  q_d  = rol_res;
                  so_d = rol_out;
               end
            end
            M_SRA: begin
               if (op_amt != '0) begin
                  q_d  = sra_res;
                  so_d = sra_out;
               end
            end
            M_CLEAR: begin
               q_d = '0;
            end
            default: begin
               q_d = q_q;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Burst FSM: next state and control
   // ------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      lat_mode_d = lat_mode_q;
      lat_amt_d  = lat_amt_q;
      busy_d     = busy_q;
      done_d     = 1'b0;          // done is a single-cycle pulse, even when paused
      exec       = 1'b0;

      if (enable) begin
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  // The launch edge only captures the burst. q is untouched.
                  lat_mode_d = mode;
                  lat_amt_d  = amount;
                  cnt_d      = burst_len;
                  state_d    = S_RUN;
                  busy_d     = 1'b1;
               end else begin
                  exec = 1'b1;
               end
            end
            S_RUN: begin
               if (cnt_q != '0) begin
                  exec  = 1'b1;
                  cnt_d = cnt_q - CNT_W'(1);
               end else begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         lat_mode_q <= M_HOLD;
         lat_amt_q  <= '0;
         q_q        <= '0;
         so_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         lat_mode_q <= lat_mode_d;
         lat_amt_q  <= lat_amt_d;
         q_q        <= q_d;
         so_q       <= so_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign q         = q_q;
   assign shift_out = so_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_multi_mode_shift_engine.sv
// ---------------------------------------------------------------------------
// tb_multi_mode_shift_engine
//
// Directed bench for multi_mode_shift_engine with WIDTH=8. The stimulus
// drives inputs on the falling edge. It also pushes the hand-computed state
// expected after the next rising edge (q, shift_out, busy, done). A separate
// monitor pops one entry after each rising clock edge and after each rst
// assertion, then compares it.
// ---------------------------------------------------------------------------
module tb_multi_mode_shift_engine;

   localparam logic [2:0] HOLD  = 3'b000;
   localparam logic [2:0] SRL   = 3'b001;
   localparam logic [2:0] SLL   = 3'b010;
   localparam logic [2:0] LOAD  = 3'b011;
   localparam logic [2:0] ROR   = 3'b100;
   localparam logic [2:0] ROL   = 3'b101;
   localparam logic [2:0] SRA   = 3'b110;
   localparam logic [2:0] CLEAR = 3'b111;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic [2:0] mode;
   logic [2:0] amount;
   logic       serial_in_right;
   logic       serial_in_left;
   logic [7:0] parallel_in;
   logic       start;
   logic [7:0] burst_len;
   logic [7:0] q;
   logic       shift_out;
   logic       busy;
   logic       done;

   typedef struct {
      string      nm;
      logic [7:0] q;
      logic       so;
      logic       b;
      logic       d;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   multi_mode_shift_engine #(.WIDTH(8), .CNT_W(8)) dut (
      .clk             (clk),
      .rst             (rst),
      .enable          (enable),
      .mode            (mode),
      .amount          (amount),
      .serial_in_right (serial_in_right),
      .serial_in_left  (serial_in_left),
      .parallel_in     (parallel_in),
      .start           (start),
      .burst_len       (burst_len),
      .q               (q),
      .shift_out       (shift_out),
      .busy            (busy),
      .done            (done)
   );

   always #5 clk = ~clk;

   task automatic push_exp(input string nm, input logic [7:0] eq, input logic eso,
                           input logic eb, input logic ed);
      exp_t e;
      e.nm = nm; e.q = eq; e.so = eso; e.b = eb; e.d = ed;
      sb.push_back(e);
   endtask

   // Drive one cycle of inputs and record the state expected after the edge.
   task automatic op(input string nm, input logic [2:0] m, input logic [2:0] a,
                     input logic en, input logic st, input logic [7:0] bl,
                     input logic [7:0] pin, input logic sil, input logic sir,
                     input logic [7:0] eq, input logic eso, input logic eb, input logic ed);
      @(negedge clk);
      mode = m; amount = a; enable = en; start = st; burst_len = bl;
      parallel_in = pin; serial_in_left = sil; serial_in_right = sir;
      push_exp(nm, eq, eso, eb, ed);
   endtask

   // Monitor / scoreboard
   initial begin
      exp_t e;
      forever begin
         @(posedge clk or posedge rst);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ({q, shift_out, busy, done} !== {e.q, e.so, e.b, e.d}) begin
               errors++;
               $display("FAIL %s: got q=%h so=%b busy=%b done=%b, want q=%h so=%b busy=%b done=%b",
                        e.nm, q, shift_out, busy, done, e.q, e.so, e.b, e.d);
            end else begin
               $display("ok   %s: q=%h so=%b busy=%b done=%b", e.nm, q, shift_out, busy, done);
            end
         end
      end
   end

   // Watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
      $fatal(1, "watchdog expired");
   end

   logic [7:0] walk [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};

   initial begin
      rst = 1'b1; enable = 1'b0; mode = HOLD; amount = 3'd0; start = 1'b0;
      burst_len = 8'd0; parallel_in = 8'h00; serial_in_left = 1'b0; serial_in_right = 1'b0;
      repeat (2) @(negedge clk);
      op("reset_state", HOLD, 0, 1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;

      // Asynchronous reset during a burst
      op("t1_load",    LOAD, 0, 1, 0, 0, 8'h5A, 0, 0, 8'h5A, 0, 0, 0);
      op("t1_start",   ROR,  1, 1, 1, 5, 8'h00, 0, 0, 8'h5A, 0, 1, 0);
      op("t1_run1",    HOLD, 0, 1, 0, 0, 8'h00, 0, 0, 8'h2D, 0, 1, 0);
      op("t1_run2",    HOLD, 0, 1, 0, 0, 8'h00, 0, 0, 8'h96, 1, 1, 0);
      @(negedge clk);
      push_exp("t1_async_rst", 8'h00, 0, 0, 0);
      #2 rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      op("t1_after",   HOLD, 0, 1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0);

      // Rotates
      op("t2_load_b4", LOAD, 0, 1, 0, 0, 8'hB4, 0, 0, 8'hB4, 0, 0, 0);
      op("t2_ror3",    ROR,  3, 1, 0, 0, 8'h00, 0, 0, 8'h96, 1, 0, 0);
      op("t2_rol3",    ROL,  3, 1, 0, 0, 8'h00, 0, 0, 8'hB4, 0, 0, 0);

      // Shifts, zero amount, clear
      op("t3_load_90", LOAD, 0, 1, 0, 0, 8'h90, 0, 0, 8'h90, 0, 0, 0);
      op("t3_sra2",    SRA,  2, 1, 0, 0, 8'h00, 0, 0, 8'hE4, 0, 0, 0);
      op("t3_load_81", LOAD, 0, 1, 0, 0, 8'h81, 0, 0, 8'h81, 0, 0, 0);
      op("t3_sll1",    SLL,  1, 1, 0, 0, 8'h00, 1, 0, 8'h03, 1, 0, 0);
      op("t3_srl0",    SRL,  0, 1, 0, 0, 8'h00, 0, 1, 8'h03, 1, 0, 0);
      op("t3_srl2_f1", SRL,  2, 1, 0, 0, 8'h00, 0, 1, 8'hC0, 1, 0, 0);
      op("t3_sll3_f0", SLL,  3, 1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0);
      op("t3_load_a5", LOAD, 0, 1, 0, 0, 8'hA5, 0, 0, 8'hA5, 0, 0, 0);
      op("t3_ror0",    ROR,  0, 1, 0, 0, 8'h00, 0, 0, 8'hA5, 0, 0, 0);
      op("t3_clear",   CLEAR,0, 1, 0, 0, 8'hFF, 0, 0, 8'h00, 0, 0, 0);
      op("t3_load_7c", LOAD, 0, 1, 0, 0, 8'h7C, 0, 0, 8'h7C, 0, 0, 0);
      op("t3_sra3_pos",SRA,  3, 1, 0, 0, 8'h00, 0, 0, 8'h0F, 1, 0, 0);

      // Burst of 8 ROL with input noise during the burst
      op("t4_load_01", LOAD, 0, 1, 0, 0, 8'h01, 0, 0, 8'h01, 1, 0, 0);
      op("t4_start",   ROL,  1, 1, 1, 8, 8'h00, 0, 0, 8'h01, 1, 1, 0);
      for (int k = 0; k < 8; k++) begin
         op("t4_run", (k % 2 == 0) ? CLEAR : LOAD, 5, 1, 1, 3, 8'hFF, 1, 1,
            walk[k], (k == 7), 1, 0);
      end
      op("t4_done",    HOLD, 0, 1, 0, 0, 8'h00, 0, 0, 8'h01, 1, 0, 1);
      op("t4_idle",    HOLD, 0, 1, 0, 0, 8'h00, 0, 0, 8'h01, 1, 0, 0);

      // Same burst with a two-cycle pause
      op("t5_start",   ROL,  1, 1, 1, 8, 8'h00, 0, 0, 8'h01, 1, 1, 0);
      for (int k = 0; k < 3; k++)
         op("t5_run", HOLD, 0, 1, 0, 0, 8'h00, 0, 0, walk[k], 0, 1, 0);
      op("t5_pause1",  CLEAR,0, 0, 1, 0, 8'h00, 0, 0, 8'h08, 0, 1, 0);
      op("t5_pause2",  CLEAR,0, 0, 1, 0, 8'h00, 0, 0, 8'h08, 0, 1, 0);
      for (int k = 3; k < 8; k++)
         op("t5_run", HOLD, 0, 1, 0, 0, 8'h00, 0, 0, walk[k], (k == 7), 1, 0);
      op("t5_done",    HOLD, 0, 1, 0, 0, 8'h00, 0, 0, 8'h01, 1, 0, 1);
      op("t5_idle",    HOLD, 0, 1, 0, 0, 8'h00, 0, 0, 8'h01, 1, 0, 0);

      // Zero-length burst, pause at count 0, done clearing with enable low
      op("t6_start0",  ROL,  1, 1, 1, 0, 8'h00, 0, 0, 8'h01, 1, 1, 0);
      op("t6_pause",   HOLD, 0, 0, 0, 0, 8'h00, 0, 0, 8'h01, 1, 1, 0);
      op("t6_done",    HOLD, 0, 1, 0, 0, 8'h00, 0, 0, 8'h01, 1, 0, 1);
      op("t6_done_clr",HOLD, 0, 0, 0, 0, 8'h00, 0, 0, 8'h01, 1, 0, 0);
      op("t6_start_en0",ROL, 1, 0, 1, 4, 8'h00, 0, 0, 8'h01, 1, 0, 0);
      op("t6_idle",    HOLD, 0, 1, 0, 0, 8'h00, 0, 0, 8'h01, 1, 0, 0);
      op("t6_load_en0",LOAD, 0, 0, 0, 0, 8'hAA, 0, 0, 8'h01, 1, 0, 0);

      // Latched LOAD samples parallel_in live
      op("t7_start",   LOAD, 0, 1, 1, 2, 8'h00, 0, 0, 8'h01, 1, 1, 0);
      op("t7_run1",    HOLD, 0, 1, 0, 0, 8'h3C, 0, 0, 8'h3C, 1, 1, 0);
      op("t7_run2",    HOLD, 0, 1, 0, 0, 8'hC3, 0, 0, 8'hC3, 1, 1, 0);
      op("t7_done",    HOLD, 0, 1, 0, 0, 8'h00, 0, 0, 8'hC3, 1, 0, 1);

      repeat (2) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: got %0d pending entries, want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
